// File: rtl/inv_chain_pkg.sv
// Shared types and constants for the inverter-chain pulse sequencer.
//   state_t      : sequencer FSM states
//   SYNC_STAGES  : depth of the chain_out synchronizer
//   LAT_TIMEOUT  : latency code reported when a pulse sees no output edge
//                  (all-ones at the default 16-bit counter width)
package inv_chain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int SYNC_STAGES = 2;
   localparam int LAT_W_DEF   = 16;
   localparam logic [LAT_W_DEF-1:0] LAT_TIMEOUT = '1;

endpackage

// File: rtl/inv_chain_edge_sync.sv
// Synchronizer plus edge detector for the asynchronous chain output.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous input (chain_out)
//   clr        : suppresses edge reporting this cycle (window start)
//   rise, fall : single-cycle synchronized edge strobes
module inv_chain_edge_sync
   import inv_chain_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   input  logic clr,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_out;
      end
   end

   // An edge seen while clr is high belongs to the previous pulse window.
   assign rise = sync_out & ~prev_q & ~clr;
   assign fall = ~sync_out & prev_q & ~clr;

endmodule

// File: rtl/inv_chain_pulse_seq.sv
// Pulse-train sequencer and rising-edge latency meter for an inverter chain.
//   cfg_width/cfg_gap/cfg_count : pulse high/low cycles (0 => 1), pulse count
//   start                       : run request, ignored while busy
//   busy, done                  : run in progress, end-of-run strobe
//   chain_in, chain_out         : registered drive, asynchronous return
//   meas_valid/idx/latency      : per-pulse result on the last LOW cycle
//   timeout_err                 : sticky per run, some pulse saw no edge
// Optional macro INV_CHAIN_PULSE_SEQ_FALL_MEAS_EN adds meas_fall_latency,
// the falling-edge latency measured from the first LOW cycle.
module inv_chain_pulse_seq
   import inv_chain_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [CNT_W-1:0] cfg_gap,
   input  logic [IDX_W-1:0] cfg_count,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             chain_in,
   input  logic             chain_out,
   output logic             meas_valid,
   output logic [IDX_W-1:0] meas_idx,
   output logic [CNT_W-1:0] meas_latency,
`ifdef INV_CHAIN_PULSE_SEQ_FALL_MEAS_EN
   output logic [CNT_W-1:0] meas_fall_latency,
`endif
   output logic             timeout_err
);

   localparam logic [CNT_W-1:0] LAT_ONES = '1;

   state_t           state;
   logic [CNT_W-1:0] width_q, gap_q, phase_q;
   logic [IDX_W-1:0] count_q, idx_q;
   logic [CNT_W-1:0] lat_cnt, rise_cap, lat_hold;
   logic             got_rise;
   logic             first_high, high_end, last_low, final_pulse, launch;
   logic             enter_high, rise, fall, rise_hit, rise_miss, pulse_miss;
   logic [CNT_W-1:0] rise_res;

   assign first_high  = (state == ST_HIGH) && (phase_q == '0);
   assign high_end    = (state == ST_HIGH) && (phase_q == width_q - CNT_W'(1));
   assign last_low    = (state == ST_LOW) && (phase_q == gap_q - CNT_W'(1));
   assign final_pulse = (idx_q == count_q - IDX_W'(1));
   assign launch      = (state == ST_IDLE) && start && (cfg_count != '0);
   assign enter_high  = launch || (last_low && !final_pulse);

   inv_chain_edge_sync u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (chain_out),
      .clr  (first_high),
      .rise (rise),
      .fall (fall)
   );

   // Rising-edge measurement: window is the whole HIGH+LOW span. An edge in
   // the last LOW cycle is folded in combinationally so it still counts.
   assign rise_hit  = rise && !got_rise && (state == ST_HIGH || state == ST_LOW);
   assign rise_miss = !got_rise && !rise_hit;
   assign rise_res  = got_rise ? rise_cap : (rise_hit ? lat_cnt : LAT_ONES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_cnt  <= '0;
         got_rise <= 1'b0;
         rise_cap <= '0;
      end else begin
         if (enter_high)             lat_cnt <= '0;
         else if (lat_cnt != LAT_ONES) lat_cnt <= lat_cnt + CNT_W'(1);
         if (enter_high)    got_rise <= 1'b0;
         else if (rise_hit) got_rise <= 1'b1;
         if (rise_hit) rise_cap <= lat_cnt;
      end
   end

`ifdef INV_CHAIN_PULSE_SEQ_FALL_MEAS_EN
   logic [CNT_W-1:0] fall_cnt, fall_cap, fall_hold, fall_res;
   logic             got_fall, fall_hit;

   // Falling-edge window is the LOW phase only; counter starts at LOW entry.
   assign fall_hit   = fall && !got_fall && (state == ST_LOW);
   assign fall_res   = got_fall ? fall_cap : (fall_hit ? fall_cnt : LAT_ONES);
   assign pulse_miss = rise_miss || (!got_fall && !fall_hit);
   assign meas_fall_latency = last_low ? fall_res : fall_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fall_cnt  <= '0;
         got_fall  <= 1'b0;
         fall_cap  <= '0;
         fall_hold <= '0;
      end else begin
         if (high_end)                  fall_cnt <= '0;
         else if (fall_cnt != LAT_ONES) fall_cnt <= fall_cnt + CNT_W'(1);
         if (high_end)      got_fall <= 1'b0;
         else if (fall_hit) got_fall <= 1'b1;
         if (fall_hit) fall_cap  <= fall_cnt;
         if (last_low) fall_hold <= fall_res;
      end
   end
`else
   logic unused_fall;
   assign unused_fall = fall;
   assign pulse_miss  = rise_miss;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         chain_in    <= 1'b0;
         width_q     <= CNT_W'(1);
         gap_q       <= CNT_W'(1);
         count_q     <= '0;
         phase_q     <= '0;
         idx_q       <= '0;
         lat_hold    <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               width_q <= (cfg_width == '0) ? CNT_W'(1) : cfg_width;
               gap_q   <= (cfg_gap == '0) ? CNT_W'(1) : cfg_gap;
               count_q <= cfg_count;
               phase_q <= '0;
               idx_q   <= '0;
               if (cfg_count == '0) begin
                  state <= ST_DONE;
               end else begin
                  state       <= ST_HIGH;
                  chain_in    <= 1'b1;
                  timeout_err <= 1'b0;
               end
            end
            ST_HIGH: begin
               if (high_end) begin
                  state    <= ST_LOW;
                  chain_in <= 1'b0;
                  phase_q  <= '0;
               end else begin
                  phase_q <= phase_q + CNT_W'(1);
               end
            end
            ST_LOW: begin
               if (last_low) begin
                  lat_hold <= rise_res;
                  phase_q  <= '0;
                  if (pulse_miss) timeout_err <= 1'b1;
                  if (final_pulse) begin
                     state <= ST_DONE;
                  end else begin
                     state    <= ST_HIGH;
                     chain_in <= 1'b1;
                     idx_q    <= idx_q + IDX_W'(1);
                  end
               end else begin
                  phase_q <= phase_q + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy         = (state != ST_IDLE);
   assign done         = (state == ST_DONE);
   assign meas_valid   = last_low;
   assign meas_idx     = idx_q;
   assign meas_latency = last_low ? rise_res : lat_hold;

endmodule

// File: tb/tb_inv_chain_pulse_seq.sv
// Self-checking bench for inv_chain_pulse_seq: directed and random runs
// against a cycle-indexed reference model of the pulse train and latency.
module tb_inv_chain_pulse_seq;
   import inv_chain_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] cfg_width = '0, cfg_gap = '0;
   logic [7:0]  cfg_count = '0;
   logic        start = 1'b0;
   logic        busy, done, chain_in, chain_out, meas_valid, timeout_err;
   logic [7:0]  meas_idx;
   logic [15:0] meas_latency;
`ifdef INV_CHAIN_PULSE_SEQ_FALL_MEAS_EN
   logic [15:0] meas_fall_latency;
`endif

   int n_chk = 0, n_pass = 0;
   int mode = 0;          // 0: delayed copy, 1: stuck low, 2: stuck high
   int dly = 0;
   logic [15:0] hist = '0;
   bit tmo_prev = 1'b0;

   inv_chain_pulse_seq dut (
      .clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
      .cfg_count(cfg_count), .start(start), .busy(busy), .done(done),
      .chain_in(chain_in), .chain_out(chain_out), .meas_valid(meas_valid),
      .meas_idx(meas_idx), .meas_latency(meas_latency),
`ifdef INV_CHAIN_PULSE_SEQ_FALL_MEAS_EN
      .meas_fall_latency(meas_fall_latency),
`endif
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Chain model: chain_out(t) = chain_in(t - dly)
   always @(posedge clk) hist <= {hist[14:0], chain_in};
   assign chain_out = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 :
                      (dly == 0) ? chain_in : hist[dly-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic set_chain(input int m, input int d);
      mode = m;
      dly  = d;
      repeat (12) @(negedge clk);
   endtask

   // Expected latency: edge arrives dly cycles after the drive edge, plus the
   // 2-cycle synchronizer, and must land inside its measurement window.
   function automatic int exp_lat(input int win);
      if (mode != 0 || dly + 2 > win - 1) return int'(LAT_TIMEOUT);
      return dly + 2;
   endfunction

   task automatic run(input int w, input int g, input int c, input bit mid);
      int we, ge, per, tot, p, off, er, ef;
      bit exp_tmo, miss;
      we  = (w == 0) ? 1 : w;
      ge  = (g == 0) ? 1 : g;
      per = we + ge;
      tot = c * per;
      cfg_width = 16'(w); cfg_gap = 16'(g); cfg_count = 8'(c); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_tmo = (c == 0) ? tmo_prev : 1'b0;
      for (int t = 1; t <= tot + 1; t++) begin
         if (mid && t == 2) begin
            start = 1'b1;
            cfg_width = 16'($urandom_range(0, 9));
            cfg_gap   = 16'($urandom_range(0, 9));
            cfg_count = 8'($urandom_range(0, 9));
         end
         if (mid && t == 3) start = 1'b0;
         p   = (t - 1) / per;
         off = (t - 1) % per;
         chk("timeout_err", timeout_err, exp_tmo);
         if (t <= tot) begin
            chk("chain_in", chain_in, off < we);
            chk("busy", busy, 1);
            chk("done", done, 0);
            chk("meas_valid", meas_valid, off == per - 1);
            if (off == per - 1) begin
               er = exp_lat(per);
               chk("meas_idx", meas_idx, p);
               chk("meas_latency", meas_latency, er);
               miss = (er == int'(LAT_TIMEOUT));
`ifdef INV_CHAIN_PULSE_SEQ_FALL_MEAS_EN
               ef = exp_lat(ge);
               chk("meas_fall_latency", meas_fall_latency, ef);
               miss = miss || (ef == int'(LAT_TIMEOUT));
`else
               ef = 0;
`endif
               if (miss) exp_tmo = 1'b1;
            end
         end else begin
            chk("done_end", done, 1);
            chk("busy_end", busy, 1);
            chk("chain_in_end", chain_in, 0);
            chk("meas_valid_end", meas_valid, 0);
         end
         @(negedge clk);
      end
      chk("busy_idle", busy, 0);
      chk("done_idle", done, 0);
      chk("timeout_idle", timeout_err, exp_tmo);
      tmo_prev = exp_tmo;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_chain_in"}, chain_in, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_meas_valid"}, meas_valid, 0);
      chk({tag, "_meas_idx"}, meas_idx, 0);
      chk({tag, "_meas_latency"}, meas_latency, 0);
      chk({tag, "_timeout"}, timeout_err, 0);
   endtask

   initial begin
      int w, g, c, ge, per, maxd;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_state("por");
      rst_n = 1'b1;
      set_chain(0, 0);

      // Basic zero-delay run
      run(4, 6, 3, 0);

      // Reset mid-HIGH: chain_in drops immediately, run is abandoned
      cfg_width = 16'd10; cfg_gap = 16'd4; cfg_count = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_reset_chain_in", chain_in, 1);
      #2 rst_n = 1'b0;
      #1 chk_reset_state("midrun");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("abort_no_done", done, 0);
         chk("abort_no_valid", meas_valid, 0);
         @(negedge clk);
      end
      tmo_prev = 1'b0;

      // Delayed chain, stuck output, count zero, width/gap zero, mid-run pokes
      set_chain(0, 5); run(8, 8, 2, 0);
      set_chain(1, 0); run(3, 4, 2, 0);
      run(2, 2, 0, 0);
      set_chain(0, 0); run(0, 0, 2, 0);
      set_chain(0, 2); run(5, 5, 3, 1);
      set_chain(0, 3); run(6, 6, 2, 0);

      // Random runs
      for (int k = 0; k < 40; k++) begin
         w   = $urandom_range(0, 6);
         g   = $urandom_range(0, 8);
         c   = $urandom_range(0, 4);
         ge  = (g == 0) ? 1 : g;
         per = ((w == 0) ? 1 : w) + ge;
         maxd = (per >= 3) ? (((ge - 1) < (per - 3)) ? ge - 1 : per - 3) : 0;
         if ($urandom_range(0, 9) < 7) set_chain(0, $urandom_range(0, maxd));
         else set_chain($urandom_range(1, 2), 0);
         run(w, g, c, $urandom_range(0, 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/inv_chain_pulse_seq.md
# inv_chain_pulse_seq

Pulse sequencer and delay-measurement controller for the inverter-chain delay-characterization datapath. It drives the chain input with a programmed train of pulses: each pulse has a programmed high width and low gap, in clock cycles. It samples the chain output through a synchronizer and reports the per-pulse rising-edge propagation latency in clock cycles. It sits between the host configuration logic and the chain under test.

## Interface
- CNT_W, 16: width of width/gap/latency counters
- IDX_W, 8: width of pulse count and pulse index
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_width  in  CNT_W  high time per pulse, cycles (0 treated as 1)
- cfg_gap  in  CNT_W  low time per pulse, cycles (0 treated as 1)
- cfg_count  in  IDX_W  number of pulses per run
- start  in  1  single-cycle run request
- busy  out  1  run in progress
- done  out  1  single-cycle end-of-run strobe
- chain_in  out  1  registered drive to chain input
- chain_out  in  1  asynchronous chain output
- meas_valid  out  1  single-cycle strobe, one per pulse
- meas_idx  out  IDX_W  index of reported pulse, 0-based
- meas_latency  out  CNT_W  rising-edge latency in cycles; all-ones on timeout
- timeout_err  out  1  sticky per run; set if any pulse gets no output rise

## Operation
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE:
  - start latches cfg_* into shadow registers.
  - If cfg_count==0, go to DONE. Otherwise go to HIGH with idx=0 and clear timeout_err.
  - start while busy is ignored. cfg_* changes mid-run have no effect.
- HIGH: chain_in=1 for width cycles, then go to LOW.
- LOW: chain_in=0 for gap cycles.
  - At the last LOW cycle: meas_valid=1 and meas_idx=idx.
  - If idx==count-1, go to DONE. Otherwise idx++ and go to HIGH.
- DONE: done=1 for one cycle, then go to IDLE. busy=0 in IDLE only.
- Measurement:
  - Latency counter clears to 0 in the first HIGH cycle (the cycle chain_in is 1) and increments each cycle.
  - The first synchronized rising edge of chain_out within the pulse window (HIGH+LOW) captures the count. Later edges in the same window are ignored.
  - If no edge is seen by the last LOW cycle: meas_latency=all-ones and timeout_err is set.
- Counter saturates at all-ones.
- The chain is non-inverting end-to-end (even stage count), so chain_out follows chain_in.

## Timing
- Reset values (asynchronous on rst_n low): state=IDLE, chain_in=0, busy=0, done=0, meas_valid=0, meas_idx=0, meas_latency=0, timeout_err=0.
- Reset mid-run forces chain_in low immediately. No meas_valid or done is issued for the aborted run.
- start sampled at cycle 0 → busy=1 and chain_in=1 from cycle 1.
- A pulse occupies exactly width+gap cycles. Run length = count*(width+gap) cycles, plus 1 DONE cycle.
- Synchronizer: 2 flops plus an edge-detect register. Zero-delay chain → meas_latency=2. The reported value includes the fixed 2-cycle synchronizer offset.
- The edge detector is cleared at each HIGH entry, so a stale edge from the previous window is not counted.

## Configuration
- INV_CHAIN_PULSE_SEQ_FALL_MEAS_EN:
  - Defined: adds output meas_fall_latency (CNT_W). Its counter clears in the first LOW cycle, and the first synchronized falling edge in LOW captures it. A missing fall yields all-ones and sets timeout_err.
  - Undefined: the port and its logic are absent; only rising latency is measured.

## Structure
- Package inv_chain_pkg holds:
  - state enum (IDLE/HIGH/LOW/DONE)
  - LAT_TIMEOUT constant (all-ones)
  - SYNC_STAGES=2
- Sub-module inv_chain_edge_sync: 2-flop synchronizer with rise/fall detect and a clear input, reset by rst_n.

## Test plan
- Reset values: assert rst_n low mid-HIGH → chain_in=0 asynchronously; all outputs at reset values; no done.
- Basic run: width=4, gap=6, count=3, zero-delay chain → chain_in high on cycles 1-4, 11-14, 21-24; meas_valid at cycles 10, 20, 30 with idx 0, 1, 2 and latency 2; done at cycle 31.
- Delayed chain: model chain delay of 5 cycles, width=8, gap=8 → latency 7; timeout_err=0.
- Timeout: chain_out stuck 0, count=2 → both meas_latency=0xFFFF; timeout_err=1 until the next start.
- Boundary values: count=0 → done on cycle 1 with no meas_valid. width=0, gap=0 → behaves as 1/1. start pulsed while busy → ignored; cfg change mid-run → no effect.
- Macro defined: delay 3 cycles each edge, width=6, gap=6 → meas_latency=5, meas_fall_latency=5.
